alu_serial_link: RTL

Synthesizable, parametrised serial-link engine for the serial ALU interface. It replaces the hand-written bench tasks that serialise commands and collect responses. The transmit side accepts an operand pair plus opcode over a valid/ready handshake, then serialises it onto `sin` as framed bytes with a CRC4 trailer. The receive side deframes response packets from `sout` and presents the data bytes and control byte as a single response beat. It sits between the test sequencer (or a host block) and the ALU's serial pins.

---
 rtl/alu_serial_link.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_serial_link.sv
// Serial-link engine for the ALU: frames operand/opcode commands onto sin with a
// CRC4 trailer, and deframes response packets arriving on sout.
module alu_serial_link #(
    parameter int OPERAND_BYTES = 4,
    parameter int GAP           = 0,
    parameter int RSP_MAX_BYTES = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [8*OPERAND_BYTES-1:0]         cmd_a,
    input  logic [8*OPERAND_BYTES-1:0]         cmd_b,
    input  logic [2:0]                         cmd_op,
    input  logic                               cmd_crc_err,
    input  logic                               cmd_short,
    output logic                               sin,
    input  logic                               sout,
    output logic                               rsp_valid,
    output logic [8*RSP_MAX_BYTES-1:0]         rsp_data,
    output logic [$clog2(RSP_MAX_BYTES+1)-1:0] rsp_nbytes,
    output logic [7:0]                         rsp_ctl,
    output logic                               rsp_overflow,
    output logic                               rsp_frame_err,
    output logic                               busy
);
    localparam int DW    = 16 * OPERAND_BYTES;
    localparam int NDATA = 2 * OPERAND_BYTES;
    localparam int FCW   = $clog2(NDATA + 1);
    localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int NBW   = $clog2(RSP_MAX_BYTES + 1);
    localparam int RW    = 8 * RSP_MAX_BYTES;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_LOAD = 2'd1;
    localparam logic [1:0] TX_SEND = 2'd2;
    localparam logic [1:0] TX_GAP  = 2'd3;

    localparam logic [1:0] RX_HUNT = 2'd0;
    localparam logic [1:0] RX_TYPE = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;
    localparam logic [1:0] RX_STOP = 2'd3;

    logic [1:0]     tx_state_q, tx_state_d;
    logic [DW-1:0]  data_q, data_d;
    logic [2:0]     op_q, op_d;
    logic           crc_err_q, crc_err_d;
    logic           short_q, short_d;
    logic [7:0]     ctl_q, ctl_d;
    logic [FCW-1:0] frames_q, frames_d;
    logic [3:0]     bit_q, bit_d;
    logic [GW-1:0]  gap_q, gap_d;

    logic [DW+3:0]  crc_stream;
    logic [3:0]     crc_calc;
    logic           crc_fb;
    logic [7:0]     cur_byte;

    // CRC over {B, A, 1, op}, MSB first, unrolled so it completes within LOAD.
    always_comb begin
        crc_stream = {data_q, 1'b1, op_q};
        crc_calc   = '0;
        crc_fb     = 1'b0;
        for (int unsigned i = 0; i < DW + 4; i++) begin
            crc_fb   = crc_calc[3] ^ crc_stream[DW + 3 - i];
            crc_calc = {crc_calc[2:0], 1'b0} ^ (crc_fb ? 4'b0011 : 4'b0000);
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        data_d     = data_q;
        op_d       = op_q;
        crc_err_d  = crc_err_q;
        short_d    = short_q;
        ctl_d      = ctl_q;
        frames_d   = frames_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (cmd_valid) begin
                    tx_state_d = TX_LOAD;
                    data_d     = {cmd_b, cmd_a};
                    op_d       = cmd_op;
                    crc_err_d  = cmd_crc_err;
                    short_d    = cmd_short;
                end
            end
            TX_LOAD: begin
                tx_state_d = TX_SEND;
                ctl_d      = {1'b0, op_q, crc_calc ^ {3'b000, crc_err_q}};
                frames_d   = short_q ? FCW'(NDATA - 1) : FCW'(NDATA);
                bit_d      = '0;
            end
            TX_SEND: begin
                if (bit_q == 4'd10) begin
                    bit_d = '0;
                    if (frames_q == '0) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        // frames_q counts data frames still to send; zero selects the control frame
                        frames_d = frames_q - 1'b1;
                        data_d   = data_q << 8;
                        if (GAP > 0) begin
                            tx_state_d = TX_GAP;
                            gap_d      = GAP_LAST;
                        end
                    end
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: begin
                if (gap_q == '0) tx_state_d = TX_SEND;
                else             gap_d      = gap_q - 1'b1;
            end
        endcase
    end

    always_comb begin
        cur_byte = (frames_q != '0) ? data_q[DW-1 -: 8] : ctl_q;
        sin      = 1'b1;
        if (tx_state_q == TX_SEND) begin
            case (bit_q)
                4'd0:    sin = 1'b0;
                4'd1:    sin = (frames_q == '0);
                4'd10:   sin = 1'b1;
                default: sin = cur_byte[3'(4'd9 - bit_q)];
            endcase
        end
    end

    assign cmd_ready = (tx_state_q == TX_IDLE);
    assign busy      = (tx_state_q != TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            data_q     <= '0;
            op_q       <= '0;
            crc_err_q  <= 1'b0;
            short_q    <= 1'b0;
            ctl_q      <= '0;
            frames_q   <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            data_q     <= data_d;
            op_q       <= op_d;
            crc_err_q  <= crc_err_d;
            short_q    <= short_d;
            ctl_q      <= ctl_d;
            frames_q   <= frames_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
        end
    end

    logic [1:0]     rx_state_q, rx_state_d;
    logic [2:0]     rx_bit_q, rx_bit_d;
    logic           rx_type_q, rx_type_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic [RW-1:0]  rsp_data_q, rsp_data_d;
    logic [NBW-1:0] rsp_nbytes_q, rsp_nbytes_d;
    logic [7:0]     rsp_ctl_q, rsp_ctl_d;
    logic           rsp_ovf_q, rsp_ovf_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_bit_d     = rx_bit_q;
        rx_type_d    = rx_type_q;
        rx_shift_d   = rx_shift_q;
        rsp_data_d   = rsp_data_q;
        rsp_nbytes_d = rsp_nbytes_q;
        rsp_ctl_d    = rsp_ctl_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_valid_d  = 1'b0;
        frame_err_d  = 1'b0;
        // count and overflow stay visible for the whole rsp_valid cycle, then clear
        if (rsp_valid_q) begin
            rsp_nbytes_d = '0;
            rsp_ovf_d    = 1'b0;
        end
        case (rx_state_q)
            RX_HUNT: begin
                if (!sout) rx_state_d = RX_TYPE;
            end
            RX_TYPE: begin
                rx_type_d  = sout;
                rx_bit_d   = '0;
                rx_state_d = RX_DATA;
            end
            RX_DATA: begin
                rx_shift_d = {rx_shift_q[6:0], sout};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            default: begin
                rx_state_d = RX_HUNT;
                if (sout) begin
                    if (rx_type_q) begin
                        rsp_ctl_d   = rx_shift_q;
                        rsp_valid_d = 1'b1;
                    end else begin
                        rsp_data_d = (rsp_data_q << 8) | RW'(rx_shift_q);
                        if (rsp_nbytes_q == NBW'(RSP_MAX_BYTES)) rsp_ovf_d    = 1'b1;
                        else                                     rsp_nbytes_d = rsp_nbytes_q + 1'b1;
                    end
                end else begin
                    frame_err_d  = 1'b1;
                    rsp_nbytes_d = '0;
                    rsp_ovf_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_HUNT;
            rx_bit_q     <= '0;
            rx_type_q    <= 1'b0;
            rx_shift_q   <= '0;
            rsp_data_q   <= '0;
            rsp_nbytes_q <= '0;
            rsp_ctl_q    <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_bit_q     <= rx_bit_d;
            rx_type_q    <= rx_type_d;
            rx_shift_q   <= rx_shift_d;
            rsp_data_q   <= rsp_data_d;
            rsp_nbytes_q <= rsp_nbytes_d;
            rsp_ctl_q    <= rsp_ctl_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_valid_q  <= rsp_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_nbytes    = rsp_nbytes_q;
    assign rsp_ctl       = rsp_ctl_q;
    assign rsp_overflow  = rsp_ovf_q;
    assign rsp_frame_err = frame_err_q;
endmodule
